// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
//   Shared types and default parameter values for the multi-read-port
//   register file (regfile_mp) and its read-port sub-module.
//
//   Contents:
//     state_e        - clear sequencer state (CLEAR, IDLE)
//     DEF_*          - default values for the regfile_mp parameters
// -----------------------------------------------------------------------------
package regfile_pkg;

    // CLEAR is the reset state: storage is zeroed one entry per cycle.
    // IDLE is normal operation: writes and reads are serviced.
    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_e;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_NUM_RD   = 2;
    localparam int DEF_ZERO_REG = 1;
    localparam int DEF_BYPASS   = 1;

endpackage : regfile_pkg

// File: rtl/regfile_if.sv
// -----------------------------------------------------------------------------
// regfile_if
//   Bundles the register file's control, write-port and read-port signals.
//   Clock and reset are not part of the bundle; they stay plain ports.
//
//   Signals:
//     clr_req   master->slave  one-cycle pulse, start a clear sequence
//     busy      slave->master  clear sequence in progress
//     wea       master->slave  write enable
//     addra     master->slave  write address
//     dina      master->slave  write data
//     rd_en     master->slave  per-port read enable (NUM_RD bits)
//     addrb     master->slave  read addresses, port i at [i*ADDR_W +: ADDR_W]
//     doutb     slave->master  read data, port i at [i*DATA_W +: DATA_W]
//     dout_vld  slave->master  port i doutb updated this cycle
//
//   Handshake: there is no back-pressure. While busy is low, a write with
//   wea=1 and a read with rd_en[i]=1 are accepted on the rising edge they are
//   presented. dout_vld[i] is high for exactly the one cycle following an
//   accepted read on port i, and doutb[i] holds its value at all other times.
//   While busy is high, wea and rd_en are discarded and dout_vld stays low.
// -----------------------------------------------------------------------------
interface regfile_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD
) ();

    logic                     clr_req;
    logic                     busy;
    logic                     wea;
    logic [ADDR_W-1:0]        addra;
    logic [DATA_W-1:0]        dina;
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] addrb;
    logic [NUM_RD*DATA_W-1:0] doutb;
    logic [NUM_RD-1:0]        dout_vld;

    // Register file side.
    modport slave (
        input  clr_req,
        input  wea,
        input  addra,
        input  dina,
        input  rd_en,
        input  addrb,
        output busy,
        output doutb,
        output dout_vld
    );

    // Decode / writeback side.
    modport master (
        output clr_req,
        output wea,
        output addra,
        output dina,
        output rd_en,
        output addrb,
        input  busy,
        input  doutb,
        input  dout_vld
    );

endinterface : regfile_if

// File: rtl/regfile_rd_port.sv
// -----------------------------------------------------------------------------
// regfile_rd_port
//   One registered read port of the register file. Selects the addressed
//   storage entry, optionally forwards same-cycle write data, forces entry 0
//   to read as zero when the zero register is enabled, and registers the
//   result.
//
//   Ports:
//     clka       in   clock
//     rstb       in   asynchronous active-high reset
//     en_i       in   read accepted this cycle (already qualified by IDLE)
//     addr_i     in   read address
//     mem_i      in   current storage contents
//     wr_en_i    in   write accepted this cycle (already qualified by IDLE)
//     wr_addr_i  in   write address
//     wr_data_i  in   write data
//     dout_o     out  registered read data, holds when en_i is low
//     vld_o      out  dout_o was updated on the last edge
// -----------------------------------------------------------------------------
module regfile_rd_port #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clka,
    input  logic              rstb,
    input  logic              en_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] mem_i [0:(1<<ADDR_W)-1],
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              vld_o
);

    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-1:0] dout_d;
    logic              vld_q;

    // The zero-register override is applied last so that a write to entry 0
    // in the same cycle can never leak through the bypass path.
    always_comb begin
        rd_word = mem_i[addr_i];
        if ((BYPASS != 0) && wr_en_i && (wr_addr_i == addr_i)) begin
            rd_word = wr_data_i;
        end
        if ((ZERO_REG != 0) && (addr_i == '0)) begin
            rd_word = '0;
        end
    end

    always_comb begin
        dout_d = dout_q;
        if (en_i) begin
            dout_d = rd_word;
        end
    end

    always_ff @(posedge clka or posedge rstb) begin
        if (rstb) begin
            dout_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            dout_q <= dout_d;
            vld_q  <= en_i;
        end
    end

    assign dout_o = dout_q;
    assign vld_o  = vld_q;

endmodule : regfile_rd_port

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//   Parametrised register file with one synchronous write port and NUM_RD
//   registered read ports. A clear sequencer zeroes every entry, one per
//   cycle, after reset and whenever clr_req is pulsed while idle. During a
//   clear sequence busy is high and all user traffic is discarded.
//
//   Parameters:
//     DATA_W    word width
//     ADDR_W    address width, depth = 2**ADDR_W
//     NUM_RD    number of read ports (1..4)
//     ZERO_REG  1: entry 0 reads as zero, writes to it are dropped
//     BYPASS    1: a same-cycle write to a read address forwards dina
//
//   Ports:
//     clka         in   clock, rising edge
//     rstb         in   asynchronous active-high reset
//     bus          --   regfile_if.slave (control, write and read ports)
//     dbg_state_o  out  current clear sequencer state
// -----------------------------------------------------------------------------
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int ZERO_REG = DEF_ZERO_REG,
    parameter int BYPASS   = DEF_BYPASS
) (
    input  logic       clka,
    input  logic       rstb,
    regfile_if.slave   bus,
    output state_e     dbg_state_o
);

    localparam int DEPTH = 1 << ADDR_W;

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;

    logic              idle;
    logic              wr_accept;
    logic              wr_store;

    // Storage is deliberately not reset: the clear sequence initialises it.
    logic [DATA_W-1:0] mem_q [0:DEPTH-1];

    logic [NUM_RD*DATA_W-1:0] doutb_w;
    logic [NUM_RD-1:0]        vld_w;

    assign idle = (state_q == IDLE);

    // wr_accept drives the bypass compare in the read ports; wr_store also
    // drops writes to the hardwired zero entry.
    assign wr_accept = idle && bus.wea;
    assign wr_store  = wr_accept && !((ZERO_REG != 0) && (bus.addra == '0));

    // -------------------------------------------------------------------------
    // Clear sequencer
    // -------------------------------------------------------------------------
    always_ff @(posedge clka or posedge rstb) begin
        if (rstb) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            CLEAR: begin
                // The counter wraps to zero as the last entry is written,
                // so it is already at zero for the next clear sequence.
                cnt_d = cnt_q + ADDR_W'(1);
                if (&cnt_q) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (bus.clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.busy    = !idle;
    assign dbg_state_o = state_q;

    // -------------------------------------------------------------------------
    // Storage write port
    // -------------------------------------------------------------------------
    always_ff @(posedge clka) begin
        if (!idle) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_store) begin
            mem_q[bus.addra] <= bus.dina;
        end
    end

    // -------------------------------------------------------------------------
    // Read ports
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        regfile_rd_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_rd_port (
            .clka      (clka),
            .rstb      (rstb),
            .en_i      (idle && bus.rd_en[gi]),
            .addr_i    (bus.addrb[gi*ADDR_W +: ADDR_W]),
            .mem_i     (mem_q),
            .wr_en_i   (wr_accept),
            .wr_addr_i (bus.addra),
            .wr_data_i (bus.dina),
            .dout_o    (doutb_w[gi*DATA_W +: DATA_W]),
            .vld_o     (vld_w[gi])
        );
    end

    assign bus.doutb    = doutb_w;
    assign bus.dout_vld = vld_w;

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
//   Drives three register file configurations with identical stimulus:
//     cfg0: ZERO_REG=1 BYPASS=1
//     cfg1: ZERO_REG=1 BYPASS=0
//     cfg2: ZERO_REG=0 BYPASS=1
//   Each output is compared against a behavioural model of the register file.
// -----------------------------------------------------------------------------
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;
    localparam int NCFG  = 3;

    // ---------------- clock / reset ----------------
    logic clka = 1'b0;
    logic rstb = 1'b1;
    always #5 clka = ~clka;

    // ---------------- driven inputs ----------------
    logic           clr_req = 1'b0;
    logic           wea     = 1'b0;
    logic [AW-1:0]  addra   = '0;
    logic [DW-1:0]  dina    = '0;
    logic [NR-1:0]  rd_en   = '0;
    logic [NR*AW-1:0] addrb = '0;

    // ---------------- observed outputs ----------------
    logic [NR*DW-1:0] obs_dout  [NCFG];
    logic [NR-1:0]    obs_vld   [NCFG];
    logic             obs_busy  [NCFG];
    state_e           obs_state [NCFG];

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        regfile_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

        assign bus.clr_req = clr_req;
        assign bus.wea     = wea;
        assign bus.addra   = addra;
        assign bus.dina    = dina;
        assign bus.rd_en   = rd_en;
        assign bus.addrb   = addrb;

        assign obs_dout[g] = bus.doutb;
        assign obs_vld[g]  = bus.dout_vld;
        assign obs_busy[g] = bus.busy;

        regfile_mp #(
            .DATA_W   (DW),
            .ADDR_W   (AW),
            .NUM_RD   (NR),
            .ZERO_REG ((g == 2) ? 0 : 1),
            .BYPASS   ((g == 1) ? 0 : 1)
        ) u_dut (
            .clka        (clka),
            .rstb        (rstb),
            .bus         (bus),
            .dbg_state_o (obs_state[g])
        );
    end

    // ---------------- scoreboard counters ----------------
    int errors = 0;
    int checks = 0;

    // ---------------- reference model ----------------
    int               m_left;
    logic [DW-1:0]    m_mem  [NCFG][DEPTH];
    logic [NR*DW-1:0] m_dout [NCFG];
    logic [NR-1:0]    m_vld  [NCFG];

    function automatic bit cfg_byp(int c);
        return c != 1;
    endfunction

    function automatic bit cfg_zero(int c);
        return c != 2;
    endfunction

    // After a clear finishes every entry is zero, and nothing can observe the
    // entries while it runs, so the model zeroes the whole array at once.
    function automatic void model_reset();
        m_left = DEPTH;
        for (int c = 0; c < NCFG; c++) begin
            m_dout[c] = '0;
            m_vld[c]  = '0;
            for (int i = 0; i < DEPTH; i++) m_mem[c][i] = '0;
        end
    endfunction

    function automatic void model_step();
        logic [AW-1:0] a;
        logic [DW-1:0] v;
        if (m_left > 0) begin
            m_left--;
            for (int c = 0; c < NCFG; c++) m_vld[c] = '0;
        end else begin
            for (int c = 0; c < NCFG; c++) begin
                for (int p = 0; p < NR; p++) begin
                    if (rd_en[p]) begin
                        a = addrb[p*AW +: AW];
                        v = m_mem[c][a];
                        if (cfg_byp(c) && wea && addra == a) v = dina;
                        if (cfg_zero(c) && a == 0) v = '0;
                        m_dout[c][p*DW +: DW] = v;
                    end
                end
                m_vld[c] = rd_en;
                if (wea && !(cfg_zero(c) && addra == 0)) m_mem[c][addra] = dina;
            end
            if (clr_req) begin
                m_left = DEPTH;
                for (int c = 0; c < NCFG; c++)
                    for (int i = 0; i < DEPTH; i++) m_mem[c][i] = '0;
            end
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clka);
        model_step();
        #1;
    endtask

    task automatic drive_idle();
        clr_req = 1'b0;
        wea     = 1'b0;
        addra   = '0;
        dina    = '0;
        rd_en   = '0;
        addrb   = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive_idle();
        rstb = 1'b1;
        model_reset();
        repeat (2) @(posedge clka);
        #1;
        for (int c = 0; c < NCFG; c++) begin
            checks++;
            if (obs_busy[c] !== 1'b1 || obs_dout[c] !== '0 || obs_vld[c] !== '0 || obs_state[c] !== CLEAR) begin
                errors++;
                $display("FAIL reset_values cfg%0d: busy=%b dout=%h vld=%b state=%0d, want busy=1 dout=0 vld=0 state=CLEAR",
                         c, obs_busy[c], obs_dout[c], obs_vld[c], obs_state[c]);
            end
        end
        rstb = 1'b0;
        for (int cyc = 0; cyc < DEPTH; cyc++) begin
            for (int c = 0; c < NCFG; c++) begin
                checks++;
                if (obs_busy[c] !== 1'b1) begin
                    errors++;
                    $display("FAIL init_busy cfg%0d cycle %0d: busy=%b want 1", c, cyc, obs_busy[c]);
                end
            end
            tick();
        end
        for (int c = 0; c < NCFG; c++) begin
            checks++;
            if (obs_busy[c] !== 1'b0 || obs_state[c] !== IDLE) begin
                errors++;
                $display("FAIL init_done cfg%0d: busy=%b state=%0d want busy=0 state=IDLE", c, obs_busy[c], obs_state[c]);
            end
        end
    endtask

    task automatic test_read_all();
        for (int a = 0; a < DEPTH; a++) begin
            rd_en = 2'b11;
            addrb = {AW'(DEPTH - 1 - a), AW'(a)};
            tick();
            for (int c = 0; c < NCFG; c++) begin
                checks++;
                if (obs_dout[c] !== '0 || obs_dout[c] !== m_dout[c] || obs_vld[c] !== 2'b11) begin
                    errors++;
                    $display("FAIL read_all cfg%0d addr %0d: dout=%h vld=%b want dout=0 vld=11", c, a, obs_dout[c], obs_vld[c]);
                end
            end
        end
        rd_en = '0;
        tick();
        for (int c = 0; c < NCFG; c++) begin
            checks++;
            if (obs_vld[c] !== 2'b00 || obs_dout[c] !== m_dout[c]) begin
                errors++;
                $display("FAIL read_hold cfg%0d: dout=%h vld=%b want dout=%h vld=00", c, obs_dout[c], obs_vld[c], m_dout[c]);
            end
        end
    endtask

    task automatic test_write_read();
        wea = 1'b1; addra = 5'd7; dina = 32'hDEADBEEF;
        tick();
        wea = 1'b0;
        rd_en = 2'b11; addrb = {5'd7, 5'd7};
        tick();
        rd_en = '0;
        for (int c = 0; c < NCFG; c++) begin
            checks++;
            if (obs_dout[c] !== {2{32'hDEADBEEF}} || obs_vld[c] !== 2'b11) begin
                errors++;
                $display("FAIL write_read cfg%0d: dout=%h vld=%b want %h vld=11", c, obs_dout[c], obs_vld[c], {2{32'hDEADBEEF}});
            end
        end
    endtask

    task automatic test_collision();
        logic [DW-1:0] exp;
        wea = 1'b1; addra = 5'd3; dina = 32'h00000011;
        tick();
        dina = 32'h12345678;
        rd_en = 2'b01; addrb = {5'd0, 5'd3};
        tick();
        wea = 1'b0;
        for (int c = 0; c < NCFG; c++) begin
            exp = cfg_byp(c) ? 32'h12345678 : 32'h00000011;
            checks++;
            if (obs_dout[c][DW-1:0] !== exp || obs_vld[c] !== 2'b01) begin
                errors++;
                $display("FAIL collision cfg%0d: port0=%h vld=%b want %h vld=01", c, obs_dout[c][DW-1:0], obs_vld[c], exp);
            end
        end
        // Without a simultaneous write every configuration sees the new value.
        tick();
        rd_en = '0;
        for (int c = 0; c < NCFG; c++) begin
            checks++;
            if (obs_dout[c][DW-1:0] !== 32'h12345678) begin
                errors++;
                $display("FAIL after_collision cfg%0d: port0=%h want 12345678", c, obs_dout[c][DW-1:0]);
            end
        end
    endtask

    task automatic test_zero_reg();
        logic [DW-1:0] exp;
        wea = 1'b1; addra = 5'd0; dina = 32'hFFFFFFFF;
        rd_en = 2'b11; addrb = {5'd0, 5'd0};
        tick();
        wea = 1'b0;
        for (int step = 0; step < 2; step++) begin
            for (int c = 0; c < NCFG; c++) begin
                exp = cfg_zero(c) ? 32'h0 : 32'hFFFFFFFF;
                checks++;
                if (obs_dout[c] !== {2{exp}} || obs_vld[c] !== 2'b11) begin
                    errors++;
                    $display("FAIL zero_reg cfg%0d step %0d: dout=%h vld=%b want %h vld=11", c, step, obs_dout[c], obs_vld[c], {2{exp}});
                end
            end
            if (step == 0) tick();
        end
        rd_en = '0;
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            wea   = 1'($urandom_range(0, 1));
            addra = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, DEPTH - 1));
            dina  = $urandom;
            rd_en = NR'($urandom_range(0, 3));
            addrb = {AW'($urandom_range(0, 3)), AW'($urandom_range(0, DEPTH - 1))};
            if ($urandom_range(0, 2) == 0) addrb[AW-1:0] = addra;
            tick();
            for (int c = 0; c < NCFG; c++) begin
                checks++;
                if (obs_dout[c] !== m_dout[c] || obs_vld[c] !== m_vld[c] || obs_busy[c] !== 1'b0) begin
                    errors++;
                    $display("FAIL random cfg%0d cycle %0d: dout=%h vld=%b busy=%b want dout=%h vld=%b busy=0",
                             c, i, obs_dout[c], obs_vld[c], obs_busy[c], m_dout[c], m_vld[c]);
                end
            end
        end
        drive_idle();
    endtask

    task automatic test_clear_req();
        for (int a = 0; a < DEPTH; a++) begin
            wea = 1'b1; addra = AW'(a); dina = 32'hA5000000 | a;
            tick();
        end
        // Traffic in the clr_req cycle itself is still serviced.
        clr_req = 1'b1;
        wea = 1'b1; addra = 5'd5; dina = 32'h00000055;
        rd_en = 2'b11; addrb = {5'd5, 5'd9};
        tick();
        for (int c = 0; c < NCFG; c++) begin
            checks++;
            if (obs_dout[c] !== m_dout[c] || obs_vld[c] !== 2'b11 || obs_busy[c] !== 1'b1) begin
                errors++;
                $display("FAIL clr_req_cycle cfg%0d: dout=%h vld=%b busy=%b want dout=%h vld=11 busy=1",
                         c, obs_dout[c], obs_vld[c], obs_busy[c], m_dout[c]);
            end
        end
        for (int cyc = 0; cyc < DEPTH; cyc++) begin
            clr_req = 1'($urandom_range(0, 1));
            wea     = 1'($urandom_range(0, 1));
            addra   = AW'($urandom_range(1, DEPTH - 1));
            dina    = $urandom | 32'h1;
            rd_en   = NR'($urandom_range(1, 3));
            addrb   = {AW'($urandom_range(0, DEPTH - 1)), AW'($urandom_range(0, DEPTH - 1))};
            for (int c = 0; c < NCFG; c++) begin
                checks++;
                if (obs_busy[c] !== 1'b1) begin
                    errors++;
                    $display("FAIL clear_busy cfg%0d cycle %0d: busy=%b want 1", c, cyc, obs_busy[c]);
                end
            end
            tick();
            for (int c = 0; c < NCFG; c++) begin
                checks++;
                if (obs_vld[c] !== 2'b00 || obs_dout[c] !== m_dout[c]) begin
                    errors++;
                    $display("FAIL clear_quiet cfg%0d cycle %0d: dout=%h vld=%b want dout=%h vld=00",
                             c, cyc, obs_dout[c], obs_vld[c], m_dout[c]);
                end
            end
        end
        drive_idle();
        for (int c = 0; c < NCFG; c++) begin
            checks++;
            if (obs_busy[c] !== 1'b0) begin
                errors++;
                $display("FAIL clear_done cfg%0d: busy=%b want 0", c, obs_busy[c]);
            end
        end
        for (int a = 0; a < DEPTH; a++) begin
            rd_en = 2'b11;
            addrb = {AW'(a), AW'(DEPTH - 1 - a)};
            tick();
            for (int c = 0; c < NCFG; c++) begin
                checks++;
                if (obs_dout[c] !== '0 || obs_vld[c] !== 2'b11) begin
                    errors++;
                    $display("FAIL cleared_read cfg%0d addr %0d: dout=%h vld=%b want 0 vld=11", c, a, obs_dout[c], obs_vld[c]);
                end
            end
        end
        drive_idle();
    endtask

    task automatic test_reset_mid_clear();
        wea = 1'b1; addra = 5'd9; dina = 32'hCAFEF00D;
        tick();
        wea = 1'b0;
        rd_en = 2'b11; addrb = {5'd9, 5'd9};
        tick();
        rd_en = '0;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (10) tick();
        #3;
        rstb = 1'b1;
        model_reset();
        #1;
        for (int c = 0; c < NCFG; c++) begin
            checks++;
            if (obs_busy[c] !== 1'b1 || obs_dout[c] !== '0 || obs_vld[c] !== '0 || obs_state[c] !== CLEAR) begin
                errors++;
                $display("FAIL mid_reset cfg%0d: busy=%b dout=%h vld=%b state=%0d want busy=1 dout=0 vld=0 state=CLEAR",
                         c, obs_busy[c], obs_dout[c], obs_vld[c], obs_state[c]);
            end
        end
        repeat (2) @(posedge clka);
        #1;
        rstb = 1'b0;
        for (int cyc = 0; cyc < DEPTH; cyc++) begin
            for (int c = 0; c < NCFG; c++) begin
                checks++;
                if (obs_busy[c] !== 1'b1) begin
                    errors++;
                    $display("FAIL restart_busy cfg%0d cycle %0d: busy=%b want 1", c, cyc, obs_busy[c]);
                end
            end
            tick();
        end
        for (int c = 0; c < NCFG; c++) begin
            checks++;
            if (obs_busy[c] !== 1'b0) begin
                errors++;
                $display("FAIL restart_done cfg%0d: busy=%b want 0", c, obs_busy[c]);
            end
        end
        rd_en = 2'b11; addrb = {5'd9, 5'd9};
        tick();
        rd_en = '0;
        for (int c = 0; c < NCFG; c++) begin
            checks++;
            if (obs_dout[c] !== '0 || obs_vld[c] !== 2'b11) begin
                errors++;
                $display("FAIL restart_read cfg%0d: dout=%h vld=%b want 0 vld=11", c, obs_dout[c], obs_vld[c]);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_read_all();
        test_write_read();
        test_collision();
        test_zero_reg();
        test_random(400);
        test_clear_req();
        test_reset_mid_clear();
        test_random(100);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_regfile_mp

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file for the core datapath: one synchronous write port and `NUM_RD` independent registered read ports on a single clock. It adds configurable write-to-read bypass, an optional hardwired zero register, and a hardware clear sequencer that zeroes every entry after reset or on request. It sits between decode (read addresses) and writeback (write port).

## Interface
- `DATA_W`, 32, word width in bits
- `ADDR_W`, 5, address width; depth = 2**ADDR_W
- `NUM_RD`, 2, number of read ports (1..4)
- `ZERO_REG`, 1, 1: entry 0 reads as 0 and writes to it are dropped
- `BYPASS`, 1, 1: same-cycle write to a read address forwards `dina`

- `clka`  in  1  clock, all logic on rising edge
- `rstb`  in  1  reset, asynchronous, active-high
- `clr_req`  in  1  one-cycle pulse, start clear sequence
- `busy`  out  1  clear sequence in progress
- `wea`  in  1  write enable
- `addra`  in  ADDR_W  write address
- `dina`  in  DATA_W  write data
- `rd_en`  in  NUM_RD  per-port read enable
- `addrb`  in  NUM_RD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
- `doutb`  out  NUM_RD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
- `dout_vld`  out  NUM_RD  port i `doutb` updated this cycle

## Operation
- FSM states: `CLEAR`, `IDLE`. Reset state `CLEAR`, clear counter = 0.
- `CLEAR`: each cycle write 0 to entry[counter], counter += 1; after writing entry DEPTH-1 (counter wraps to 0) go `IDLE`. `busy` = 1 throughout.
- In `CLEAR`: `wea` dropped, `rd_en` ignored, `dout_vld` = 0, `doutb` holds. `clr_req` ignored (no restart).
- `IDLE`: `clr_req` = 1 -> `CLEAR` next cycle with counter = 0; `wea`/`rd_en` in that same cycle still serviced.
- Write: `wea` in `IDLE` stores `dina` at `addra` on the rising edge. If `ZERO_REG` and `addra` = 0, dropped.
- Read port i: `rd_en[i]` in `IDLE` -> next edge `doutb[i]` = entry[addrb[i]], `dout_vld[i]` = 1. `rd_en[i]` = 0 -> `doutb[i]` holds, `dout_vld[i]` = 0.
- Collision (`wea`, `rd_en[i]`, `addra` == `addrb[i]`): `BYPASS`=1 returns `dina`; `BYPASS`=0 returns the pre-write value.
- `ZERO_REG`=1: read of address 0 returns 0 regardless of bypass.
- Multiple ports may read the same address in the same cycle; all get the same value.

## Timing
- Reset values: `doutb` = 0, `dout_vld` = 0, `busy` = 1; storage contents undefined until clear completes.
- Clear duration: exactly 2**ADDR_W cycles after `rstb` deasserts or after the `clr_req` cycle; `busy` falls on the edge that writes the last entry.
- Read latency 1 cycle; write visible to a non-bypassed read on the next cycle.
- `rstb` asserted mid-clear or mid-operation: immediately returns to reset values, and clear restarts from 0 after release.

## Structure
- Package `regfile_pkg`: FSM state enum (`CLEAR`, `IDLE`), default parameter constants.
- Sub-module `regfile_rd_port`: one read port (address mux, bypass/zero compare, output register), instantiated `NUM_RD` times by generate.
- Storage is an array in the top; counter and FSM in the top.

## Test plan
- Reset release, defaults: `busy` = 1 for 32 cycles, then 0; read all 32 addresses -> all 0x00000000, `dout_vld` = 1 one cycle after each `rd_en`.
- Write 0xDEADBEEF to addr 7, next cycle read port 0 addr 7 and port 1 addr 7 -> both 0xDEADBEEF.
- Collision: `wea` addr 3 = 0x12345678 with port 0 reading addr 3, old value 0x11 -> `BYPASS`=1 gives 0x12345678; `BYPASS`=0 gives 0x11.
- Zero register: write 0xFFFFFFFF to addr 0 -> read addr 0 returns 0 with and without bypass; with `ZERO_REG`=0 returns 0xFFFFFFFF.
- `clr_req` after filling entries with nonzero data: `busy` = 1 for 32 cycles, writes and reads during `busy` dropped (`dout_vld` = 0), afterwards all entries read 0.
- `rstb` pulsed at clear cycle 10: outputs return to reset values, `busy` stays 1 for a full 32 cycles after release.
